// File: rtl/uart_rx_if.sv
// uart_rx_if: receive-side output bundle of the UART receiver.
//   rx_data : last correctly received byte (bits above the frame width read 0)
//   rx_rdy  : one-cycle strobe, rx_data just updated
//   rx_err  : one-cycle strobe, frame ended with a low stop bit
// master = receiver (drives), slave = consumer (observes).
interface uart_rx_if;
  logic [7:0] rx_data;
  logic       rx_rdy;
  logic       rx_err;

  modport master (output rx_data, output rx_rdy, output rx_err);
  modport slave  (input  rx_data, input  rx_rdy, input  rx_err);
endinterface

// File: rtl/uart_rx.sv
// uart_rx: 8N1-style serial receiver (LSB first, DATA_BW data bits, 1 stop).
// Synchronises the asynchronous pin, finds the start edge, samples every
// bit at its centre and reports either a good byte or a framing error.
// Ports:
//   clk_50m  : system clock
//   rst      : asynchronous active-high reset
//   uart_rxd : serial line, idle high, asynchronous to clk_50m
//   rx_if    : master side of uart_rx_if (rx_data / rx_rdy / rx_err)
module uart_rx #(
  parameter int CLKS_PER_BIT = 434,
  parameter int DATA_BW      = 8
) (
  input  logic     clk_50m,
  input  logic     rst,
  input  logic     uart_rxd,
  uart_rx_if.master rx_if
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_BREAK
  } state_t;

  localparam logic [15:0] HALF_CNT = 16'(CLKS_PER_BIT / 2);
  localparam logic [15:0] LAST_CNT = 16'(CLKS_PER_BIT - 1);
  localparam logic [3:0]  LAST_IDX = 4'(DATA_BW - 1);

  state_t               state_q, state_d;
  logic                 rxd_meta_q, rxd_meta_d;
  logic                 rxd_s_q, rxd_s_d;
  logic [15:0]          cnt_q, cnt_d;
  logic [3:0]           idx_q, idx_d;
  logic [DATA_BW-1:0]   shift_q, shift_d;
  logic [7:0]           rx_data_q, rx_data_d;
  logic                 rx_rdy_q, rx_rdy_d;
  logic                 rx_err_q, rx_err_d;

  logic half_hit;
  logic bit_hit;

  assign half_hit = (cnt_q == HALF_CNT);
  assign bit_hit  = (cnt_q == LAST_CNT);

  // Two-flop synchroniser; only rxd_s_q is ever used for decisions.
  always_comb begin
    rxd_meta_d = uart_rxd;
    rxd_s_d    = rxd_meta_q;
  end

  // State register (holds every flop of the block).
  always_ff @(posedge clk_50m or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      rxd_meta_q <= 1'b1;
      rxd_s_q    <= 1'b1;
      cnt_q      <= '0;
      idx_q      <= '0;
      shift_q    <= '0;
      rx_data_q  <= '0;
      rx_rdy_q   <= 1'b0;
      rx_err_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      rxd_meta_q <= rxd_meta_d;
      rxd_s_q    <= rxd_s_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      shift_q    <= shift_d;
      rx_data_q  <= rx_data_d;
      rx_rdy_q   <= rx_rdy_d;
      rx_err_q   <= rx_err_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (!rxd_s_q) state_d = S_START;
      // Line back high at mid start bit means it was only a glitch.
      S_START: if (half_hit) state_d = rxd_s_q ? S_IDLE : S_DATA;
      S_DATA:  if (bit_hit && (idx_q == LAST_IDX)) state_d = S_STOP;
      // Leaving at mid stop bit leaves half a bit to catch the next start.
      S_STOP:  if (bit_hit) state_d = rxd_s_q ? S_IDLE : S_BREAK;
      // A held-low line must go high before another frame may begin.
      S_BREAK: if (rxd_s_q) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath and output logic.
  always_comb begin
    cnt_d     = cnt_q + 16'd1;
    idx_d     = idx_q;
    shift_d   = shift_q;
    rx_data_d = rx_data_q;
    rx_rdy_d  = 1'b0;
    rx_err_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        idx_d = '0;
      end
      S_START: begin
        if (half_hit) begin
          cnt_d = '0;
          idx_d = '0;
        end
      end
      S_DATA: begin
        if (bit_hit) begin
          // Bits arrive LSB first, so shift in from the top.
          shift_d = {rxd_s_q, shift_q[DATA_BW-1:1]};
          cnt_d   = '0;
          idx_d   = idx_q + 4'd1;
        end
      end
      S_STOP: begin
        if (bit_hit) begin
          cnt_d = '0;
          if (rxd_s_q) begin
            rx_data_d = 8'(shift_q);
            rx_rdy_d  = 1'b1;
          end else begin
            rx_err_d  = 1'b1;
          end
        end
      end
      S_BREAK: begin
        cnt_d = '0;
      end
      default: begin
        cnt_d = '0;
        idx_d = '0;
      end
    endcase
  end

  assign rx_if.rx_data = rx_data_q;
  assign rx_if.rx_rdy  = rx_rdy_q;
  assign rx_if.rx_err  = rx_err_q;

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed bench for uart_rx. Drives serial frames on uart_rxd,
// records every rx_rdy / rx_err pulse with its cycle number, and compares
// against hand-computed values through a single check task.
module tb_uart_rx;

  localparam int BIT_CLKS = 434;

  logic clk_50m = 1'b0;
  logic rst     = 1'b1;
  logic uart_rxd = 1'b1;

  uart_rx_if rx_if ();

  uart_rx #(
    .CLKS_PER_BIT(BIT_CLKS),
    .DATA_BW     (8)
  ) dut (
    .clk_50m (clk_50m),
    .rst     (rst),
    .uart_rxd(uart_rxd),
    .rx_if   (rx_if)
  );

  always #10 clk_50m = ~clk_50m;

  int unsigned cyc = 0;
  always @(posedge clk_50m) cyc <= cyc + 1;

  // Pulse monitor, sampled on the falling edge.
  int unsigned rdy_cyc_q[$];
  logic [7:0]  rdy_dat_q[$];
  int          err_cnt  = 0;
  int          both_cnt = 0;

  always @(negedge clk_50m) begin
    if (rx_if.rx_rdy) begin
      rdy_cyc_q.push_back(cyc);
      rdy_dat_q.push_back(rx_if.rx_data);
    end
    if (rx_if.rx_err) err_cnt = err_cnt + 1;
    if (rx_if.rx_rdy && rx_if.rx_err) both_cnt = both_cnt + 1;
  end

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks = checks + 1;
    if (got !== exp) begin
      errors = errors + 1;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end else begin
      $display("ok   %s: 0x%0h", tag, got);
    end
  endtask

  // Hold the line at v for n clocks; every change lands 1 ns after a rising edge.
  task automatic drive(input logic v, input int n);
    uart_rxd = v;
    repeat (n) @(posedge clk_50m);
    #1;
  endtask

  int unsigned start_cyc;

  task automatic send_frame(input logic [7:0] d, input int per, input logic stopv);
    start_cyc = cyc;
    drive(1'b0, per);
    for (int i = 0; i < 8; i++) drive(d[i], per);
    drive(stopv, per);
  endtask

  int base_rdy;
  int base_err;
  int unsigned lat;
  int unsigned b2b_start;
  logic [7:0] b2b_exp [5];

  initial begin
    b2b_exp[0] = 8'h00; b2b_exp[1] = 8'hFF; b2b_exp[2] = 8'h55;
    b2b_exp[3] = 8'h80; b2b_exp[4] = 8'h01;

    // Reset state
    repeat (3) @(posedge clk_50m);
    #1;
    check("rst_data", {24'd0, rx_if.rx_data}, 32'h0);
    check("rst_rdy",  {31'd0, rx_if.rx_rdy},  32'h0);
    check("rst_err",  {31'd0, rx_if.rx_err},  32'h0);
    rst = 1'b0;
    drive(1'b1, 20);

    // Single frame 0xA5 with latency: 3 + 217 + 9*434 (+1 for registered sample)
    base_rdy = rdy_cyc_q.size();
    base_err = err_cnt;
    send_frame(8'hA5, BIT_CLKS, 1'b1);
    drive(1'b1, 20);
    check("a5_pulses", 32'(rdy_cyc_q.size() - base_rdy), 32'd1);
    if (rdy_cyc_q.size() > base_rdy) begin
      lat = rdy_cyc_q[base_rdy] - start_cyc;
      check("a5_lat_in_4125_4127", {31'd0, (lat >= 4125 && lat <= 4127)}, 32'd1);
      check("a5_data", {24'd0, rdy_dat_q[base_rdy]}, 32'hA5);
    end
    check("a5_err", 32'(err_cnt - base_err), 32'd0);

    // Back-to-back frames, no idle gap: spacing 10*434 = 4340
    base_rdy = rdy_cyc_q.size();
    send_frame(8'h00, BIT_CLKS, 1'b1);
    b2b_start = start_cyc;
    send_frame(8'hFF, BIT_CLKS, 1'b1);
    send_frame(8'h55, BIT_CLKS, 1'b1);
    send_frame(8'h80, BIT_CLKS, 1'b1);
    send_frame(8'h01, BIT_CLKS, 1'b1);
    drive(1'b1, 20);
    check("b2b_pulses", 32'(rdy_cyc_q.size() - base_rdy), 32'd5);
    if (rdy_cyc_q.size() >= base_rdy + 5) begin
      for (int i = 0; i < 5; i++) begin
        check($sformatf("b2b_data%0d", i), {24'd0, rdy_dat_q[base_rdy + i]}, {24'd0, b2b_exp[i]});
        if (i > 0)
          check($sformatf("b2b_gap%0d", i),
                rdy_cyc_q[base_rdy + i] - rdy_cyc_q[base_rdy + i - 1], 32'd4340);
      end
    end
    check("b2b_err", 32'(err_cnt - base_err), 32'd0);

    // 100-clock glitch on the idle line, then 0x3C
    base_rdy = rdy_cyc_q.size();
    drive(1'b0, 100);
    drive(1'b1, 500);
    check("glitch_rdy", 32'(rdy_cyc_q.size() - base_rdy), 32'd0);
    check("glitch_err", 32'(err_cnt - base_err), 32'd0);
    send_frame(8'h3C, BIT_CLKS, 1'b1);
    drive(1'b1, 20);
    check("post_glitch_pulses", 32'(rdy_cyc_q.size() - base_rdy), 32'd1);
    if (rdy_cyc_q.size() > base_rdy) begin
      lat = rdy_cyc_q[base_rdy] - start_cyc;
      check("post_glitch_lat_ok", {31'd0, (lat >= 4125 && lat <= 4127)}, 32'd1);
      check("post_glitch_data", {24'd0, rdy_dat_q[base_rdy]}, 32'h3C);
    end

    // Framing error: 0x12 with low stop, line held low 5000 clocks
    base_rdy = rdy_cyc_q.size();
    base_err = err_cnt;
    send_frame(8'h12, BIT_CLKS, 1'b0);
    drive(1'b0, 5000);
    check("brk_err", 32'(err_cnt - base_err), 32'd1);
    check("brk_rdy", 32'(rdy_cyc_q.size() - base_rdy), 32'd0);
    check("brk_data_hold", {24'd0, rx_if.rx_data}, 32'h3C);
    drive(1'b1, 50);
    send_frame(8'h34, BIT_CLKS, 1'b1);
    drive(1'b1, 20);
    check("brk_next_pulses", 32'(rdy_cyc_q.size() - base_rdy), 32'd1);
    check("brk_next_data", {24'd0, rx_if.rx_data}, 32'h34);
    check("brk_err_total", 32'(err_cnt - base_err), 32'd1);

    // Reset during data bit 4 of 0x77 (bit 4 is 1)
    base_rdy = rdy_cyc_q.size();
    base_err = err_cnt;
    drive(1'b0, BIT_CLKS);
    drive(1'b1, BIT_CLKS);
    drive(1'b1, BIT_CLKS);
    drive(1'b1, BIT_CLKS);
    drive(1'b0, BIT_CLKS);
    drive(1'b1, 200);
    rst = 1'b1;
    #1;
    check("midrst_data", {24'd0, rx_if.rx_data}, 32'h0);
    check("midrst_rdy",  {31'd0, rx_if.rx_rdy},  32'h0);
    check("midrst_err",  {31'd0, rx_if.rx_err},  32'h0);
    @(posedge clk_50m);
    #1;
    rst = 1'b0;
    drive(1'b1, 1000);
    check("midrst_no_rdy", 32'(rdy_cyc_q.size() - base_rdy), 32'd0);
    check("midrst_no_err", 32'(err_cnt - base_err), 32'd0);
    send_frame(8'h99, BIT_CLKS, 1'b1);
    drive(1'b1, 20);
    check("midrst_next_pulses", 32'(rdy_cyc_q.size() - base_rdy), 32'd1);
    check("midrst_next_data", {24'd0, rx_if.rx_data}, 32'h99);

    // Baud tolerance: 425 and 443 clocks per bit
    base_rdy = rdy_cyc_q.size();
    base_err = err_cnt;
    send_frame(8'hC3, 425, 1'b1);
    drive(1'b1, 50);
    check("slowfast425_data", {24'd0, rx_if.rx_data}, 32'hC3);
    check("slowfast425_pulses", 32'(rdy_cyc_q.size() - base_rdy), 32'd1);
    drive(1'b1, 10);
    check("clear_before_443", {24'd0, rx_if.rx_data}, 32'hC3);
    send_frame(8'hC3, 443, 1'b1);
    drive(1'b1, 50);
    check("slowfast443_pulses", 32'(rdy_cyc_q.size() - base_rdy), 32'd2);
    if (rdy_dat_q.size() >= base_rdy + 2)
      check("slowfast443_data", {24'd0, rdy_dat_q[base_rdy + 1]}, 32'hC3);
    check("tol_err", 32'(err_cnt - base_err), 32'd0);

    check("rdy_err_same_cycle", 32'(both_cnt), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
# uart_rx

Serial receiver for the 115200-baud 8N1 link: it samples the asynchronous `uart_rxd` pin, reassembles each frame and presents the byte on `rx_data` with a one-cycle `rx_rdy` strobe. It sits directly downstream of the board RX pin and is the consumer of frames produced by our `uart` transmitter. It replaces that module's tied-off `rx_rdy`/`rx_data` outputs and adds framing-error reporting.

## Interface
- `CLKS_PER_BIT`, 434, clk_50m cycles per bit (50 MHz / 115200); legal range 16..65535
- `DATA_BW`, 8, data bits per frame, LSB first; legal range 5..8
- `clk_50m`  input  1  system clock, 50 MHz
- `rst`  input  1  reset; one clock; reset is asynchronous and active-high
- `uart_rxd`  input  1  serial line, idle high, asynchronous to `clk_50m`
- `rx_data`  output  8  last correctly received byte; bits above `DATA_BW-1` read 0
- `rx_rdy`  output  1  one-cycle strobe: `rx_data` just updated with a new byte
- `rx_err`  output  1  one-cycle strobe: frame ended with stop bit = 0

## Operation
- Input sync: two flops on `uart_rxd` (reset value 1). All decisions use the second flop (`rxd_s`).
- Bit counter: 16 bits, counts clocks inside a bit; bit index: 4 bits.
- States:
  - IDLE: counter held 0. `rxd_s`==0 -> START.
  - START: at counter == `CLKS_PER_BIT/2` (integer division; 217 by default), sample `rxd_s`. 1 -> IDLE (glitch, no output). 0 -> DATA, counter 0, index 0.
  - DATA: at counter == `CLKS_PER_BIT`-1, shift `rxd_s` into shift register MSB-side (LSB-first reassembly), counter 0, index+1. After sample `DATA_BW`-1 -> STOP.
  - STOP: at counter == `CLKS_PER_BIT`-1 sample `rxd_s`. 1 -> load `rx_data`, pulse `rx_rdy`, -> IDLE. 0 -> pulse `rx_err`, `rx_data` unchanged, -> BREAK.
  - BREAK: wait for `rxd_s`==1, then -> IDLE. Prevents a held-low line (break) from retriggering frames.
- Return to IDLE happens at mid-stop-bit, so a start bit immediately following the stop bit is caught.
- `rx_rdy` and `rx_err` never assert in the same cycle; each is high for exactly one cycle per frame.
- No handshake/backpressure: consumer must take `rx_data` on `rx_rdy`; `rx_data` holds until the next good frame.

## Timing
- Reset (async, any state, including mid-frame): state IDLE, counters 0, sync flops 1, shift register 0, `rx_data`=0, `rx_rdy`=0, `rx_err`=0. Partial frame discarded; first falling edge after reset release starts a fresh frame.
- Edge detect latency: falling edge at pin -> START entered 3 clock edges later (2 sync + 1 IDLE decision).
- Start sample: `CLKS_PER_BIT/2` clocks after entering START. Each subsequent sample: `CLKS_PER_BIT` clocks after the previous.
- Pin falling edge -> `rx_rdy` high: 3 + `CLKS_PER_BIT/2` + (`DATA_BW`+1)·`CLKS_PER_BIT` clocks = 3 + 217 + 3906 = 4126 at defaults. `rx_data` valid in the same cycle as `rx_rdy`.
- Glitch rejection: a low pulse shorter than `CLKS_PER_BIT/2` - 2 clocks produces no output.
- Baud tolerance: frames from a transmitter off by up to ±2% must decode correctly.
- Back-to-back frames with zero idle between stop and next start: every frame received; minimum frame period `(DATA_BW+2)·CLKS_PER_BIT`.

## Test plan
- Loopback from `uart` TX, send 0xA5 -> single `rx_rdy` pulse 4126±1 clocks after start edge, `rx_data`=0xA5, `rx_err` stays 0.
- Back-to-back 0x00, 0xFF, 0x55 with no idle gap -> three `rx_rdy` pulses 4340 clocks apart, data in order; then 0x80 and 0x01 to check bit order.
- Low glitch of 100 clocks on idle line -> no `rx_rdy`, no `rx_err`, state back in IDLE; following 0x3C frame received correctly.
- Frame 0x12 with stop bit driven 0, line held low 5000 clocks, then high, then frame 0x34 -> one `rx_err` pulse, no `rx_rdy` during the low period, `rx_data` stays previous value, then `rx_rdy` with 0x34.
- Assert `rst` during DATA bit 4 of 0x77 -> all outputs 0 immediately; release before next start edge; send 0x99 -> `rx_data`=0x99, no spurious pulse from the aborted frame.
- Bit period 425 and 443 clocks (±2%), data 0xC3 -> `rx_data`=0xC3, `rx_err`=0 in both cases.
